// File: rtl/commit_trace_buffer_pkg.sv
// Shared definitions for the commit trace buffer: field widths, trace state
// encoding and the bit layout of one trace entry {seq, pc, rd, value}.
package commit_trace_buffer_pkg;

  localparam int XLEN_DEF  = 32;
  localparam int REG_IDX_W = 5;
  localparam int NREGS     = 32;
  localparam int SEQ_W     = 32;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_CAPTURE = 2'd1,
    ST_FROZEN  = 2'd2
  } trace_state_e;

  // Entry layout, LSB first: value, rd, pc, seq.
  function automatic int entry_w(int xlen);
    return SEQ_W + xlen + REG_IDX_W + xlen;
  endfunction

  function automatic int rd_lsb(int xlen);
    return xlen;
  endfunction

  function automatic int pc_lsb(int xlen);
    return xlen + REG_IDX_W;
  endfunction

  function automatic int seq_lsb(int xlen);
    return 2 * xlen + REG_IDX_W;
  endfunction

endpackage

// File: rtl/commit_trace_buffer_if.sv
// ROB commit bus plus the trace drain port. The buffer is the slave: it
// listens to commits and presents the head entry; master is the bench/host.
interface commit_trace_buffer_if #(
  parameter int NCOMMIT = 2,
  parameter int XLEN    = 32
) ();
  import commit_trace_buffer_pkg::*;

  localparam int EW = entry_w(XLEN);

  logic [NCOMMIT-1:0]           cmt_valid_in;
  logic [NCOMMIT*XLEN-1:0]      cmt_pc_in;
  logic [NCOMMIT*REG_IDX_W-1:0] cmt_rd_in;
  logic [NCOMMIT*XLEN-1:0]      cmt_value_in;
  logic                         rd_valid_out;
  logic                         rd_ready_in;
  logic [EW-1:0]                rd_data_out;

  modport master (
    output cmt_valid_in, cmt_pc_in, cmt_rd_in, cmt_value_in, rd_ready_in,
    input  rd_valid_out, rd_data_out
  );

  modport slave (
    input  cmt_valid_in, cmt_pc_in, cmt_rd_in, cmt_value_in, rd_ready_in,
    output rd_valid_out, rd_data_out
  );

endinterface

// File: rtl/commit_trace_buffer_ring.sv
// Circular entry store with multi-push / single-pop per cycle. Pushes arrive
// compacted in push_data[0 .. push_n-1]; a pop is applied before the pushes.
// When full, OVERWRITE!=0 drops the oldest entries, otherwise the excess
// pushes are refused. Assumes DEPTH >= NCOMMIT.
module commit_trace_buffer_ring #(
  parameter  int NCOMMIT   = 2,
  parameter  int DEPTH     = 64,
  parameter  int EW        = 101,
  parameter  int OVERWRITE = 1,
  localparam int PW        = $clog2(DEPTH),
  localparam int CW        = PW + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clear,
  input  logic          pop_req,
  input  logic [CW-1:0] push_n,
  input  logic [EW-1:0] push_data [NCOMMIT],
  output logic          valid,
  output logic [EW-1:0] head_data,
  output logic [CW-1:0] count,
  output logic [CW-1:0] count_next,
  output logic [CW-1:0] accepted,
  output logic          lost
);

  logic [EW-1:0] mem [DEPTH];
  logic [PW-1:0] head, tail;
  logic          pop;
  logic [CW-1:0] pop_w, space, excess, drop;

  assign valid     = (count != '0);
  assign pop       = valid & pop_req;
  assign pop_w     = {{(CW-1){1'b0}}, pop};
  assign head_data = mem[head];

  // Occupancy arithmetic: free space after the pop, and how many pushes overflow it.
  // NOTE: every output gets a default before any branch so no latch is inferred.
  always_comb begin
    space  = CW'(DEPTH) - count + pop_w;
    excess = '0;
    lost   = 1'b0;
    if (push_n > space) begin
      excess = push_n - space;
      lost   = 1'b1;
    end
    if (OVERWRITE != 0) begin
      accepted = push_n;
      drop     = excess;
    end else begin
      accepted = push_n - excess;
      drop     = '0;
    end
    count_next = count - pop_w + accepted - drop;
  end

  // Pointer and count registers; overwritten entries push the head forward.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else if (clear) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      head  <= head + PW'(pop_w) + PW'(drop);
      tail  <= tail + PW'(accepted);
      count <= count_next;
    end
  end

  // Entry writes at consecutive slots from tail.
  // NOTE: the entry RAM is deliberately not reset; count gates validity, and
  // leaving it unreset lets it map onto block/distributed RAM.
  always_ff @(posedge clk) begin
    if (!clear) begin
      for (int k = 0; k < NCOMMIT; k++) begin
        if (CW'(k) < accepted) mem[tail + PW'(k)] <= push_data[k];
      end
    end
  end

endmodule

// File: rtl/commit_trace_buffer.sv
// Commit trace buffer: captures ROB commits into a ring while armed, keeps a
// shadow architectural register file, and flags a commit-starved pipeline.
module commit_trace_buffer
  import commit_trace_buffer_pkg::*;
#(
  parameter int NCOMMIT   = 2,
  parameter int DEPTH     = 64,
  parameter int XLEN      = XLEN_DEF,
  parameter int TIMEOUT   = 4096,
  parameter int OVERWRITE = 1
) (
  input  logic                   clk_in,
  input  logic                   rst_n_in,
  commit_trace_buffer_if.slave   bus,
  input  logic                   arm_in,
  input  logic                   freeze_in,
  input  logic                   clear_in,
  output logic [$clog2(DEPTH):0] count_out,
  output logic [1:0]             state_out,
  output logic                   overflow_out,
  output logic                   hang_out,
  input  logic [REG_IDX_W-1:0]   dbg_idx_in,
  output logic [XLEN-1:0]        dbg_val_out
);

  localparam int CW      = $clog2(DEPTH) + 1;
  localparam int EW      = entry_w(XLEN);
  localparam int RD_LSB  = rd_lsb(XLEN);
  localparam int PC_LSB  = pc_lsb(XLEN);
  localparam int SEQ_LSB = seq_lsb(XLEN);
  localparam int IW      = $clog2(TIMEOUT + 1);

  trace_state_e   state, state_next;
  logic [SEQ_W-1:0] seq;
  logic [IW-1:0]  idle_cnt;
  logic [XLEN-1:0] shadow [NREGS];
  logic           capture, any_commit, lost;
  logic [CW-1:0]  push_n, count, count_next, accepted;
  logic [EW-1:0]  push_data [NCOMMIT];
  logic           ring_valid;
  logic [EW-1:0]  ring_head;

  assign capture    = (state == ST_CAPTURE) && !clear_in;
  assign any_commit = |bus.cmt_valid_in;

  // Compact valid lanes in ascending order and stamp consecutive sequence numbers.
  always_comb begin
    int n;
    logic [EW-1:0] e;
    n = 0;
    e = '0;
    for (int l = 0; l < NCOMMIT; l++) push_data[l] = '0;
    for (int l = 0; l < NCOMMIT; l++) begin
      if (bus.cmt_valid_in[l]) begin
        e[SEQ_LSB +: SEQ_W]    = seq + SEQ_W'(n);
        e[PC_LSB +: XLEN]      = bus.cmt_pc_in[l*XLEN +: XLEN];
        e[RD_LSB +: REG_IDX_W] = bus.cmt_rd_in[l*REG_IDX_W +: REG_IDX_W];
        e[0 +: XLEN]           = bus.cmt_value_in[l*XLEN +: XLEN];
        push_data[n]           = e;
        n++;
      end
    end
    push_n = capture ? CW'(n) : '0;
  end

  commit_trace_buffer_ring #(
    .NCOMMIT  (NCOMMIT),
    .DEPTH    (DEPTH),
    .EW       (EW),
    .OVERWRITE(OVERWRITE)
  ) u_ring (
    .clk       (clk_in),
    .rst_n     (rst_n_in),
    .clear     (clear_in),
    .pop_req   (bus.rd_ready_in),
    .push_n    (push_n),
    .push_data (push_data),
    .valid     (ring_valid),
    .head_data (ring_head),
    .count     (count),
    .count_next(count_next),
    .accepted  (accepted),
    .lost      (lost)
  );

  assign bus.rd_valid_out = ring_valid;
  assign bus.rd_data_out  = ring_head;
  assign count_out        = count;
  assign state_out        = state;

  // Trace state register.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) state <= ST_IDLE;
    else           state <= state_next;
  end

  // Trace state transitions; clear overrides arm and freeze.
  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE:    if (arm_in) state_next = ST_CAPTURE;
      ST_CAPTURE: if (freeze_in || (OVERWRITE == 0 && count_next == CW'(DEPTH)))
                    state_next = ST_FROZEN;
      ST_FROZEN:  state_next = ST_FROZEN;
      default:    state_next = ST_IDLE;
    endcase
    if (clear_in) state_next = ST_IDLE;
  end

  // Sequence counter advances by the entries actually stored; overflow is sticky.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      seq          <= '0;
      overflow_out <= 1'b0;
    end else if (clear_in) begin
      seq          <= '0;
      overflow_out <= 1'b0;
    end else if (capture) begin
      seq <= seq + SEQ_W'(accepted);
      if (lost) overflow_out <= 1'b1;
    end
  end

  // No-commit watchdog: saturating idle counter, sticky hang flag.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      idle_cnt <= '0;
      hang_out <= 1'b0;
    end else if (clear_in) begin
      idle_cnt <= '0;
      hang_out <= 1'b0;
    end else if (capture) begin
      if (any_commit) begin
        idle_cnt <= '0;
      end else if (idle_cnt != IW'(TIMEOUT)) begin
        idle_cnt <= idle_cnt + IW'(1);
        if (idle_cnt == IW'(TIMEOUT - 1)) hang_out <= 1'b1;
      end
    end
  end

  // Shadow register file, updated in every state; later lanes win on the same rd.
  // Unlike the trace RAM it is small and architecturally visible, so it is reset.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      for (int r = 0; r < NREGS; r++) shadow[r] <= '0;
    end else begin
      for (int l = 0; l < NCOMMIT; l++) begin
        if (bus.cmt_valid_in[l] && bus.cmt_rd_in[l*REG_IDX_W +: REG_IDX_W] != '0)
          shadow[bus.cmt_rd_in[l*REG_IDX_W +: REG_IDX_W]] <= bus.cmt_value_in[l*XLEN +: XLEN];
      end
    end
  end

  assign dbg_val_out = shadow[dbg_idx_in];

endmodule

// File: tb/tb_commit_trace_buffer.sv
// Bench for commit_trace_buffer: one overwrite and one stop-when-full instance
// (DEPTH=8, NCOMMIT=2, TIMEOUT=16) share stimulus and are compared each cycle
// against a queue-based reference model.
module tb_commit_trace_buffer;

  typedef logic [100:0] entry_t;
  typedef entry_t entry_q_t[$];

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic [1:0]  c_valid;
  logic [63:0] c_pc, c_val;
  logic [9:0]  c_rd;
  logic        c_ready, arm, freeze, clear;
  logic [4:0]  dbg_idx;

  logic [1:0]        vld_o, ovf_o, hang_o;
  logic [1:0][100:0] dat_o;
  logic [1:0][3:0]   cnt_o;
  logic [1:0][1:0]   st_o;
  logic [1:0][31:0]  dbg_o;

  commit_trace_buffer_if #(.NCOMMIT(2), .XLEN(32)) bus_ow ();
  commit_trace_buffer_if #(.NCOMMIT(2), .XLEN(32)) bus_nw ();

  assign bus_ow.cmt_valid_in = c_valid;
  assign bus_ow.cmt_pc_in    = c_pc;
  assign bus_ow.cmt_rd_in    = c_rd;
  assign bus_ow.cmt_value_in = c_val;
  assign bus_ow.rd_ready_in  = c_ready;
  assign bus_nw.cmt_valid_in = c_valid;
  assign bus_nw.cmt_pc_in    = c_pc;
  assign bus_nw.cmt_rd_in    = c_rd;
  assign bus_nw.cmt_value_in = c_val;
  assign bus_nw.rd_ready_in  = c_ready;
  assign vld_o[0] = bus_ow.rd_valid_out;
  assign vld_o[1] = bus_nw.rd_valid_out;
  assign dat_o[0] = bus_ow.rd_data_out;
  assign dat_o[1] = bus_nw.rd_data_out;

  commit_trace_buffer #(.NCOMMIT(2), .DEPTH(8), .XLEN(32), .TIMEOUT(16), .OVERWRITE(1)) dut_ow (
    .clk_in(clk), .rst_n_in(rst_n), .bus(bus_ow), .arm_in(arm), .freeze_in(freeze),
    .clear_in(clear), .count_out(cnt_o[0]), .state_out(st_o[0]), .overflow_out(ovf_o[0]),
    .hang_out(hang_o[0]), .dbg_idx_in(dbg_idx), .dbg_val_out(dbg_o[0]));

  commit_trace_buffer #(.NCOMMIT(2), .DEPTH(8), .XLEN(32), .TIMEOUT(16), .OVERWRITE(0)) dut_nw (
    .clk_in(clk), .rst_n_in(rst_n), .bus(bus_nw), .arm_in(arm), .freeze_in(freeze),
    .clear_in(clear), .count_out(cnt_o[1]), .state_out(st_o[1]), .overflow_out(ovf_o[1]),
    .hang_out(hang_o[1]), .dbg_idx_in(dbg_idx), .dbg_val_out(dbg_o[1]));

  // Reference model: per instance a queue of entries plus scalar status.
  entry_q_t    mq [2];
  int          m_state [2];
  int unsigned m_seq [2];
  bit          m_ovf [2];
  bit          m_hang [2];
  int          m_idle [2];
  logic [31:0] m_sh [32];
  string       nm [2] = '{"ow", "nw"};

  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      mq[i].delete();
      m_state[i] = 0; m_seq[i] = 0; m_ovf[i] = 0; m_hang[i] = 0; m_idle[i] = 0;
    end
    for (int r = 0; r < 32; r++) m_sh[r] = '0;
  endtask

  // One clock edge of behaviour, from the pre-edge inputs.
  task automatic model_step();
    for (int i = 0; i < 2; i++) begin
      bit ow;
      ow = (i == 0);
      if (clear) begin
        mq[i].delete();
        m_state[i] = 0; m_seq[i] = 0; m_ovf[i] = 0; m_hang[i] = 0; m_idle[i] = 0;
      end else begin
        if (mq[i].size() > 0 && c_ready) void'(mq[i].pop_front());
        if (m_state[i] == 1) begin
          for (int l = 0; l < 2; l++) begin
            if (c_valid[l]) begin
              entry_t e;
              e = {m_seq[i], c_pc[l*32 +: 32], c_rd[l*5 +: 5], c_val[l*32 +: 32]};
              if (mq[i].size() < 8) begin
                mq[i].push_back(e); m_seq[i]++;
              end else if (ow) begin
                void'(mq[i].pop_front()); mq[i].push_back(e); m_seq[i]++; m_ovf[i] = 1;
              end else begin
                m_ovf[i] = 1;
              end
            end
          end
          if (c_valid != 2'b00) m_idle[i] = 0;
          else if (m_idle[i] < 16) begin
            m_idle[i]++;
            if (m_idle[i] == 16) m_hang[i] = 1;
          end
          if (freeze || (!ow && mq[i].size() == 8)) m_state[i] = 2;
        end else if (m_state[i] == 0 && arm) begin
          m_state[i] = 1;
        end
      end
    end
    for (int l = 0; l < 2; l++)
      if (c_valid[l] && c_rd[l*5 +: 5] != 5'd0) m_sh[c_rd[l*5 +: 5]] = c_val[l*32 +: 32];
  endtask

  task automatic check_all();
    for (int i = 0; i < 2; i++) begin
      check($sformatf("%s.rd_valid", nm[i]), vld_o[i], mq[i].size() > 0);
      if (mq[i].size() > 0) check($sformatf("%s.rd_data", nm[i]), dat_o[i], mq[i][0]);
      check($sformatf("%s.count", nm[i]), cnt_o[i], mq[i].size());
      check($sformatf("%s.state", nm[i]), st_o[i], m_state[i]);
      check($sformatf("%s.overflow", nm[i]), ovf_o[i], m_ovf[i]);
      check($sformatf("%s.hang", nm[i]), hang_o[i], m_hang[i]);
      check($sformatf("%s.dbg_val", nm[i]), dbg_o[i], m_sh[dbg_idx]);
    end
  endtask

  // Called at a falling edge with inputs already set; pulses drop afterwards.
  task automatic step();
    @(posedge clk);
    model_step();
    @(negedge clk);
    check_all();
    arm = 0; freeze = 0; clear = 0; c_valid = 2'b00;
  endtask

  task automatic commit1(input logic [31:0] pc, input logic [4:0] rd, input logic [31:0] v);
    c_valid = 2'b01; c_pc[31:0] = pc; c_rd[4:0] = rd; c_val[31:0] = v;
  endtask

  task automatic commit2(input logic [31:0] pc0, input logic [4:0] rd0, input logic [31:0] v0,
                         input logic [31:0] pc1, input logic [4:0] rd1, input logic [31:0] v1);
    c_valid = 2'b11; c_pc = {pc1, pc0}; c_rd = {rd1, rd0}; c_val = {v1, v0};
  endtask

  initial begin
    rst_n = 0; c_valid = 0; c_pc = 0; c_val = 0; c_rd = 0; c_ready = 0;
    arm = 0; freeze = 0; clear = 0; dbg_idx = 0;
    model_reset();
    repeat (2) @(negedge clk);
    check_all();
    rst_n = 1;
    @(negedge clk);
    check_all();

    // Single-lane capture, then in-order drain.
    arm = 1; step();
    for (int k = 0; k < 5; k++) begin
      commit1(32'h1000 + 32'(4 * k), 5'(k + 1), $urandom); step();
    end
    check("t1.count_ow", cnt_o[0], 5);
    check("t1.count_nw", cnt_o[1], 5);
    c_ready = 1;
    for (int k = 0; k < 5; k++) begin
      check($sformatf("t1.seq%0d", k), dat_o[0][100:69], k);
      step();
    end
    c_ready = 0;
    check("t1.drained", cnt_o[0], 0);

    // Dual-lane commit, same rd on both lanes, then a write to x0.
    dbg_idx = 5;
    commit2(32'h10, 5'd5, 32'hAA, 32'h14, 5'd5, 32'hBB); step();
    check("t2.count", cnt_o[0], 2);
    check("t2.head_seq", dat_o[0][100:69], 5);
    check("t2.head_pc", dat_o[0][68:37], 32'h10);
    check("t6.dbg5_ow", dbg_o[0], 32'hBB);
    check("t6.dbg5_nw", dbg_o[1], 32'hBB);
    dbg_idx = 0;
    commit1(32'h18, 5'd0, 32'h123); step();
    check("t6.dbg0", dbg_o[0], 0);

    // Fill to 7, then a dual commit crosses the full boundary.
    for (int k = 0; k < 4; k++) begin
      commit1(32'h20 + 32'(4 * k), 5'($urandom_range(1, 31)), $urandom); step();
    end
    check("t4.count7", cnt_o[1], 7);
    commit2(32'h40, 5'd7, $urandom, 32'h44, 5'd8, $urandom); step();
    check("t3.count_ow", cnt_o[0], 8);
    check("t3.ovf_ow", ovf_o[0], 1);
    check("t3.head_seq_ow", dat_o[0][100:69], 6);
    check("t3.state_ow", st_o[0], 1);
    check("t4.count_nw", cnt_o[1], 8);
    check("t4.ovf_nw", ovf_o[1], 1);
    check("t4.state_nw", st_o[1], 2);
    check("t4.head_seq_nw", dat_o[1][100:69], 5);
    clear = 1; step();
    check("clr.count", cnt_o[1], 0);
    check("clr.state", st_o[1], 0);

    // Watchdog.
    arm = 1; step();
    repeat (15) step();
    check("t5.no_hang_15", hang_o[0], 0);
    step();
    check("t5.hang_16_ow", hang_o[0], 1);
    check("t5.hang_16_nw", hang_o[1], 1);
    commit1($urandom, 5'd3, $urandom); step();
    check("t5.hang_sticky", hang_o[0], 1);
    clear = 1; step();
    check("t5.hang_cleared", hang_o[0], 0);

    // Randomized traffic with occasional control pulses.
    arm = 1; step();
    for (int n = 0; n < 600; n++) begin
      c_valid = 2'($urandom);
      c_pc    = {$urandom, $urandom};
      c_val   = {$urandom, $urandom};
      c_rd    = {5'($urandom_range(0, 7)), 5'($urandom_range(0, 7))};
      c_ready = 1'($urandom_range(0, 1));
      arm     = ($urandom_range(0, 9) == 0);
      freeze  = ($urandom_range(0, 39) == 0);
      clear   = ($urandom_range(0, 59) == 0);
      dbg_idx = 5'($urandom_range(0, 7));
      step();
    end

    // Asynchronous reset in the middle of a drain.
    c_ready = 0; clear = 1; step();
    arm = 1; step();
    for (int k = 0; k < 6; k++) begin
      commit2($urandom, 5'd1, $urandom, $urandom, 5'd2, $urandom); step();
    end
    c_ready = 1; step();
    @(posedge clk);
    model_step();
    #2 rst_n = 0;
    #1;
    check("rst.valid_ow", vld_o[0], 0);
    check("rst.valid_nw", vld_o[1], 0);
    check("rst.count_ow", cnt_o[0], 0);
    check("rst.count_nw", cnt_o[1], 0);
    model_reset();
    @(negedge clk);
    check_all();
    rst_n = 1;
    repeat (3) step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
